// File: rtl/key_expansion_seq_if.sv
// Round-key stream bundle between the key-schedule engine and its user.
// The requester (master) drives start/key; the engine (slave) returns the round-key stream.
interface key_expansion_seq_if;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_index;
   logic [127:0] rk_data;
   logic         done;

   modport master (
      output start, key,
      input  busy, rk_valid, rk_index, rk_data, done
   );

   modport slave (
      input  start, key,
      output busy, rk_valid, rk_index, rk_data, done
   );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one expanded word per clock, round keys emitted as a
// valid-qualified stream every 4 cycles (11 keys, rounds 0..10).
module key_expansion_seq (
   input logic               clk,
   input logic               reset,
   key_expansion_seq_if.slave bus
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLoad   = 2'd1;
   localparam logic [1:0] StExpand = 2'd2;

   localparam logic [5:0] LastWord = 6'd43;
   localparam logic [5:0] EndCount = 6'd44;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse (x^254, maps 0 to 0) followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] base;
      logic [7:0] b;
      r    = 8'h01;
      base = x;
      // 254 = 8'b1111_1110: multiply in every power except x^1
      for (int k = 0; k < 8; k++) begin
         if (k != 0) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [7:0] idx);
      logic [7:0] c;
      case (idx)
         8'd1:    c = 8'h01;
         8'd2:    c = 8'h02;
         8'd3:    c = 8'h04;
         8'd4:    c = 8'h08;
         8'd5:    c = 8'h10;
         8'd6:    c = 8'h20;
         8'd7:    c = 8'h40;
         8'd8:    c = 8'h80;
         8'd9:    c = 8'h1b;
         8'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   logic [1:0]   state_q;
   logic [31:0]  w0_q, w1_q, w2_q, w3_q;
   logic [5:0]   cnt_q;
   logic         rk_valid_q;
   logic         done_q;
   logic [3:0]   rk_index_q;
   logic [127:0] rk_data_q;

   logic [31:0]  temp;
   logic [31:0]  new_word;
   logic [7:0]   rcon_idx;

   // Next schedule word w[i] from the sliding window w[i-4..i-1]
   always_comb begin
      rcon_idx = {2'b00, cnt_q[5:2]};
      temp     = w3_q;
      if (cnt_q[1:0] == 2'b00) begin
         temp = sub_word({w3_q[23:0], w3_q[31:24]}) ^ {rcon(rcon_idx), 24'h000000};
      end
      new_word = w0_q ^ temp;
   end

   // FSM, word window, counter and registered round-key outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         w0_q       <= '0;
         w1_q       <= '0;
         w2_q       <= '0;
         w3_q       <= '0;
         cnt_q      <= '0;
         rk_valid_q <= 1'b0;
         done_q     <= 1'b0;
         rk_index_q <= '0;
         rk_data_q  <= '0;
      end else begin
         rk_valid_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q    <= StLoad;
                  w0_q       <= bus.key[127:96];
                  w1_q       <= bus.key[95:64];
                  w2_q       <= bus.key[63:32];
                  w3_q       <= bus.key[31:0];
                  cnt_q      <= 6'd4;
                  rk_valid_q <= 1'b1;
                  rk_index_q <= 4'd0;
                  rk_data_q  <= bus.key;
               end
            end
            StLoad, StExpand: begin
               if (cnt_q == EndCount) begin
                  // Round 10 is on the outputs this cycle; go idle behind it
                  state_q <= StIdle;
               end else begin
                  state_q <= StExpand;
                  w0_q    <= w1_q;
                  w1_q    <= w2_q;
                  w2_q    <= w3_q;
                  w3_q    <= new_word;
                  cnt_q   <= cnt_q + 6'd1;
                  if (cnt_q[1:0] == 2'b11) begin
                     rk_valid_q <= 1'b1;
                     rk_index_q <= cnt_q[5:2];
                     rk_data_q  <= {w1_q, w2_q, w3_q, new_word};
                     done_q     <= (cnt_q == LastWord);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.rk_valid = rk_valid_q;
   assign bus.rk_index = rk_index_q;
   assign bus.rk_data  = rk_data_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq using FIPS-197 and all-zero key vectors.
module tb_key_expansion_seq;

   localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] OtherKey = 128'h000102030405060708090a0b0c0d0e0f;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   key_expansion_seq_if bus ();

   key_expansion_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log, filled on the falling edge
   logic [3:0]   log_idx  [64];
   logic [127:0] log_data [64];
   int           log_cyc  [64];
   int           done_cyc [16];
   int           n_pulse = 0;
   int           n_done = 0;

   always @(negedge clk) begin
      if (bus.rk_valid && n_pulse < 64) begin
         log_idx[n_pulse]  = bus.rk_index;
         log_data[n_pulse] = bus.rk_data;
         log_cyc[n_pulse]  = cyc;
         n_pulse++;
      end
      if (bus.done && n_done < 16) begin
         done_cyc[n_done] = cyc;
         n_done++;
      end
   end

   int e0;
   int base;
   int dbase;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic do_start(input logic [127:0] k);
      bus.key   = k;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.key   = ~k;
      e0    = cyc;
      base  = n_pulse;
      dbase = n_done;
   endtask

   task automatic get_pulse(input int r, output logic [127:0] d, output int c);
      d = '0;
      c = -1;
      for (int j = base; j < n_pulse; j++) begin
         if (int'(log_idx[j]) == r && c < 0) begin
            d = log_data[j];
            c = log_cyc[j];
         end
      end
   endtask

   logic [127:0] d;
   int           c;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.key   = '0;
      tick();
      tick();
      check("reset_busy", 128'(bus.busy), 128'd0);
      check("reset_rk_valid", 128'(bus.rk_valid), 128'd0);
      check("reset_done", 128'(bus.done), 128'd0);
      check("reset_rk_index", 128'(bus.rk_index), 128'd0);
      check("reset_rk_data", bus.rk_data, 128'd0);
      reset = 1'b0;
      tick();

      // FIPS-197 key, full run with timing
      do_start(FipsKey);
      check("fips_busy_first", 128'(bus.busy), 128'd1);
      run_to(e0 + 40);
      check("fips_busy_last", 128'(bus.busy), 128'd1);
      check("fips_done_live", 128'(bus.done), 128'd1);
      run_to(e0 + 41);
      check("fips_busy_drop", 128'(bus.busy), 128'd0);
      run_to(e0 + 45);
      check("fips_pulse_count", 128'(n_pulse - base), 128'd11);
      for (int r = 0; r <= 10; r++) begin
         get_pulse(r, d, c);
         check($sformatf("fips_r%0d_cycle", r), 128'(c - e0), 128'(4 * r));
      end
      get_pulse(0, d, c);
      check("fips_r0_data", d, FipsKey);
      get_pulse(1, d, c);
      check("fips_r1_data", d, FipsR1);
      get_pulse(10, d, c);
      check("fips_r10_data", d, FipsR10);
      check("fips_done_count", 128'(n_done - dbase), 128'd1);
      check("fips_done_cycle", 128'(done_cyc[dbase] - e0), 128'd40);

      // All-zero key
      do_start('0);
      run_to(e0 + 45);
      check("zero_pulse_count", 128'(n_pulse - base), 128'd11);
      for (int j = 0; j < 11; j++) begin
         check($sformatf("zero_order_%0d", j), 128'(log_idx[base + j]), 128'(j));
      end
      get_pulse(1, d, c);
      check("zero_r1_data", d, ZeroR1);
      get_pulse(10, d, c);
      check("zero_r10_data", d, ZeroR10);

      // start re-pulsed mid-run with another key is ignored
      do_start(FipsKey);
      run_to(e0 + 9);
      bus.key   = OtherKey;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      run_to(e0 + 50);
      check("repulse_pulse_count", 128'(n_pulse - base), 128'd11);
      get_pulse(10, d, c);
      check("repulse_r10_data", d, FipsR10);
      check("repulse_r10_cycle", 128'(c - e0), 128'd40);

      // reset mid-expansion aborts
      do_start('0);
      run_to(e0 + 19);
      reset = 1'b1;
      tick();
      check("abort_busy", 128'(bus.busy), 128'd0);
      check("abort_rk_valid", 128'(bus.rk_valid), 128'd0);
      check("abort_done", 128'(bus.done), 128'd0);
      check("abort_rk_data", bus.rk_data, 128'd0);
      reset = 1'b0;
      run_to(e0 + 70);
      check("abort_pulse_count", 128'(n_pulse - base), 128'd5);
      check("abort_done_count", 128'(n_done - dbase), 128'd0);

      // back-to-back: start held through the done cycle, accepted one cycle later
      do_start(FipsKey);
      run_to(e0 + 40);
      bus.key   = '0;
      bus.start = 1'b1;
      tick();
      tick();
      bus.start = 1'b0;
      run_to(e0 + 90);
      check("b2b_pulse_count", 128'(n_pulse - base), 128'd22);
      check("b2b_done_count", 128'(n_done - dbase), 128'd2);
      check("b2b_done1_cycle", 128'(done_cyc[dbase] - e0), 128'd40);
      check("b2b_done2_cycle", 128'(done_cyc[dbase + 1] - e0), 128'd82);
      check("b2b_second_r1", log_data[base + 12], ZeroR1);
      check("b2b_second_r1_cycle", 128'(log_cyc[base + 12] - e0), 128'd46);

      // reset and start together
      base      = n_pulse;
      bus.key   = FipsKey;
      reset     = 1'b1;
      bus.start = 1'b1;
      tick();
      reset     = 1'b0;
      bus.start = 1'b0;
      check("rst_start_busy", 128'(bus.busy), 128'd0);
      repeat (6) tick();
      check("rst_start_busy_later", 128'(bus.busy), 128'd0);
      check("rst_start_no_pulse", 128'(n_pulse - base), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
